// File: rtl/sram_burst_ctrl.sv
// Bridges a CPU word request onto an asynchronous SRAM of width DQ_W,
// splitting each word into BEATS little-endian accesses of WAIT_CYC cycles.
module sram_burst_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DQ_W     = 16,
  parameter int unsigned BEATS    = 2,
  parameter int unsigned WAIT_CYC = 3,
  parameter int unsigned SRAM_AW  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DQ_W*BEATS-1:0]     wdata,
  input  logic [DQ_W*BEATS/8-1:0]   be,
  output logic [DQ_W*BEATS-1:0]     rdata,
  output logic                      ready,
  inout  wire  [DQ_W-1:0]           SRAM_DQ,
  output logic [SRAM_AW-1:0]        SRAM_ADDR,
  output logic [DQ_W/8-1:0]         SRAM_BE_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N
);

  localparam int unsigned WORD_W = DQ_W * BEATS;
  localparam int unsigned LANES  = DQ_W / 8;
  localparam int unsigned BE_W   = WORD_W / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned BSH    = $clog2(BEATS);
  localparam int unsigned BEAT_W = (BEATS > 1) ? BSH : 1;
  localparam int unsigned CNT_W  = $clog2(WAIT_CYC);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WAIT_CYC - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic [ADDR_W-1:0]   word_addr;
  logic [SRAM_AW-1:0]  sram_addr_d;
  logic [LANES-1:0]    sram_be_n_d;
  logic                sram_we_n_d, sram_ce_n_d, sram_oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [DQ_W-1:0]     dq_out_q, dq_out_d;

  // State, latched request and registered SRAM pins; reset parks the bus immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      beat_q    <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      SRAM_ADDR <= '0;
      SRAM_BE_N <= '1;
      SRAM_WE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      beat_q    <= beat_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      SRAM_ADDR <= sram_addr_d;
      SRAM_BE_N <= sram_be_n_d;
      SRAM_WE_N <= sram_we_n_d;
      SRAM_CE_N <= sram_ce_n_d;
      SRAM_OE_N <= sram_oe_n_d;
      dq_oe_q   <= dq_oe_d;
      dq_out_q  <= dq_out_d;
    end
  end

  // Next state plus next SRAM pin values, decoded from the next state so pins stay glitch-free
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    beat_d      = beat_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    word_addr   = '0;
    sram_addr_d = SRAM_ADDR;
    sram_be_n_d = '1;
    sram_we_n_d = 1'b1;
    sram_ce_n_d = 1'b1;
    sram_oe_n_d = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;

    unique case (state_q)
      IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ACCESS;
          rd_d    = rd_en;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          wcnt_d  = '0;
          beat_d  = '0;
        end
      end
      ACCESS: begin
        if (wcnt_q == LAST_CNT) begin
          wcnt_d = '0;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ACCESS) begin
      word_addr   = ((addr_d >> OFF_W) << BSH) | ADDR_W'(beat_d);
      sram_addr_d = SRAM_AW'(word_addr);
      sram_ce_n_d = 1'b0;
      if (rd_d) begin
        sram_oe_n_d = 1'b0;
        sram_be_n_d = '0;
      end else begin
        dq_oe_d     = 1'b1;
        dq_out_d    = wdata_d[int'(beat_d)*DQ_W +: DQ_W];
        sram_be_n_d = ~be_d[int'(beat_d)*LANES +: LANES];
        sram_we_n_d = (wcnt_d == LAST_CNT);
      end
    end
  end

  // Read beats land in their little-endian slice on the last cycle of the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (state_q == ACCESS && rd_q && wcnt_q == LAST_CNT) begin
      rdata[int'(beat_q)*DQ_W +: DQ_W] <= SRAM_DQ;
    end
  end

  assign ready   = ((state_q == IDLE) && !(rd_en || wr_en)) || (state_q == DONE);
  assign SRAM_DQ = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};

endmodule
